// File: rtl/reg_write_arbiter.sv
// Arbitrates NREQ requesters onto the load port of a single register. The arbiter is round-robin,
// with an optional bounded lock. Define REG_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module reg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*DW-1:0]      wdata,
    output logic                    load,
    output logic [DW-1:0]           load_data,
    output logic [NREQ-1:0]         gnt,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] owner_id
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t          state;
    logic [CW-1:0]   lock_cnt;
    logic [NREQ-1:0] elig;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;

`ifdef REG_ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] winner_next;

    assign ptr         = rr_ptr;
    assign winner_next = (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
`endif

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int offs);
        int s;
        s = (int'(base) + offs) % NREQ;
        return PW'(s);
    endfunction

    // Registered ack masks the requester just served, preventing a double grant.
    assign elig = req & ~ack;

    // Scan downward so the smallest offset from ptr is the last assignment, and therefore wins.
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (elig[wrap_idx(ptr, i)]) begin
                winner = wrap_idx(ptr, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB;
            lock_cnt  <= '0;
            load      <= 1'b0;
            load_data <= '0;
            gnt       <= '0;
            ack       <= '0;
            owner_id  <= '0;
`ifndef REG_ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            load <= 1'b0;
            gnt  <= '0;
            ack  <= '0;
            case (state)
                ARB: begin
                    if (|elig) begin
                        load      <= 1'b1;
                        load_data <= wdata[int'(winner)*DW +: DW];
                        gnt       <= ONE << winner;
                        ack       <= ONE << winner;
                        owner_id  <= winner;
`ifndef REG_ARB_FIXED_PRIO_EN
                        rr_ptr    <= winner_next;
`endif
                        // lock_cnt counts writes already done in the burst; MAX_LOCK=1 never locks.
                        if (lock[winner] && (MAX_LOCK > 1)) begin
                            state    <= LOCKED;
                            lock_cnt <= CW'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (req[owner_id]) begin
                        load      <= 1'b1;
                        load_data <= wdata[int'(owner_id)*DW +: DW];
                        gnt       <= ONE << owner_id;
                        ack       <= ONE << owner_id;
                        if (lock[owner_id] && (lock_cnt < CW'(MAX_LOCK - 1))) begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end else begin
                            state    <= ARB;
                            lock_cnt <= '0;
                        end
                    end else begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the arbitration rules.
module tb_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 8;

`ifdef REG_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    lock;
    logic [NREQ*DW-1:0] wdata;
    logic               load;
    logic [DW-1:0]      load_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [1:0]         owner_id;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    logic            m_load;
    logic [DW-1:0]   m_data;
    logic [NREQ-1:0] m_gnt;
    logic [NREQ-1:0] m_ack;
    logic [1:0]      m_owner;
    int              m_ptr;
    bit              m_locked;
    int              m_burst;

    reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .wdata    (wdata),
        .load     (load),
        .load_data(load_data),
        .gnt      (gnt),
        .ack      (ack),
        .owner_id (owner_id)
    );

    always #5 clk = ~clk;

    task automatic model_write(input int w);
        m_load        = 1'b1;
        m_data        = wdata[w*DW +: DW];
        m_gnt         = '0;
        m_gnt[w]      = 1'b1;
        m_ack         = m_gnt;
    endtask

    task automatic model_edge();
        logic [NREQ-1:0] elig;
        int w;
        if (rst) begin
            m_load = 1'b0; m_data = '0; m_gnt = '0; m_ack = '0; m_owner = '0;
            m_ptr = 0; m_locked = 1'b0; m_burst = 0;
        end else begin
            elig   = req & ~m_ack;
            m_load = 1'b0;
            m_gnt  = '0;
            m_ack  = '0;
            if (m_locked) begin
                if (req[m_owner]) begin
                    model_write(int'(m_owner));
                    m_burst++;
                    if (!lock[m_owner] || m_burst >= MAX_LOCK) begin
                        m_locked = 1'b0;
                        m_burst  = 0;
                    end
                end else begin
                    m_locked = 1'b0;
                    m_burst  = 0;
                end
            end else if (elig != '0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int c;
                    c = FIXED ? k : (m_ptr + k) % NREQ;
                    if (w < 0 && elig[c]) w = c;
                end
                model_write(w);
                m_owner = 2'(w);
                m_ptr   = (w + 1) % NREQ;
                m_burst = 1;
                if (lock[w] && m_burst < MAX_LOCK) m_locked = 1'b1;
                else m_burst = 0;
            end
        end
    endtask

    // one clock edge; the model sees the same inputs the DUT samples
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        wdata[i*DW +: DW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; lock = '0; wdata = '0;
        step(); step();
        vectors++;
        if ({load, load_data, gnt, ack, owner_id} !== '0) begin
            miscompares++;
            $display("FAIL reset: got load=%b data=%h gnt=%b ack=%b owner=%0d, expected all zero",
                     load, load_data, gnt, ack, owner_id);
        end
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < NREQ; i++) set_data(i, 32'h5A00_0000 + i);
        req = 4'b1111; lock = '0;
        for (int k = 0; k < NREQ; k++) begin
            step();
            vectors++;
            if ({load, ack, gnt, owner_id, load_data} !==
                {1'b1, 4'(1 << k), 4'(1 << k), 2'(k), 32'h5A00_0000 + k}) begin
                miscompares++;
                $display("FAIL round_robin[%0d]: got load=%b ack=%b gnt=%b owner=%0d data=%h, expected owner %0d",
                         k, load, ack, gnt, owner_id, load_data, k);
            end
            req[k] = 1'b0;
        end
        step();
        vectors++;
        if ({load, gnt, ack} !== '0) begin
            miscompares++;
            $display("FAIL round_robin_idle: got load=%b gnt=%b ack=%b, expected 0", load, gnt, ack);
        end
    endtask

    task automatic test_single();
        set_data(2, 32'h00F4_30FE);
        req = 4'b0100; lock = '0;
        step();
        vectors++;
        if ({load, ack, gnt, load_data, owner_id} !== {1'b1, 4'b0100, 4'b0100, 32'h00F4_30FE, 2'd2}) begin
            miscompares++;
            $display("FAIL single_write: got load=%b ack=%b gnt=%b data=%h owner=%0d, expected 1 0100 0100 00f430fe 2",
                     load, ack, gnt, load_data, owner_id);
        end
        req = '0;
        step();
        vectors++;
        if ({load, gnt, ack, load_data} !== {1'b0, 4'b0000, 4'b0000, 32'h00F4_30FE}) begin
            miscompares++;
            $display("FAIL single_release: got load=%b gnt=%b ack=%b data=%h, expected 0 0000 0000 00f430fe",
                     load, gnt, ack, load_data);
        end
    endtask

    task automatic test_priority();
        int first, second;
        first  = FIXED ? 0 : 3;
        second = FIXED ? 3 : 0;
        set_data(0, 32'h0000_AAAA); set_data(3, 32'h3333_BBBB);
        req = 4'b1001; lock = '0;
        step();
        vectors++;
        if ({load, owner_id, ack} !== {1'b1, 2'(first), 4'(1 << first)}) begin
            miscompares++;
            $display("FAIL priority_first: got load=%b owner=%0d ack=%b, expected owner %0d", load, owner_id, ack, first);
        end
        req[first] = 1'b0;
        step();
        vectors++;
        if ({load, owner_id, ack} !== {1'b1, 2'(second), 4'(1 << second)}) begin
            miscompares++;
            $display("FAIL priority_second: got load=%b owner=%0d ack=%b, expected owner %0d", load, owner_id, ack, second);
        end
        req = '0;
        step();
    endtask

    task automatic test_lock_max();
        req = 4'b0010; lock = 4'b0010;
        for (int k = 1; k <= MAX_LOCK; k++) begin
            set_data(1, 32'hA000_0000 + k);
            set_data(0, 32'hB0B0_0000 + k);
            step();
            vectors++;
            if ({load, ack, owner_id, load_data} !== {1'b1, 4'b0010, 2'd1, 32'hA000_0000 + k}) begin
                miscompares++;
                $display("FAIL lock_burst[%0d]: got load=%b ack=%b owner=%0d data=%h, expected owner 1 data %h",
                         k, load, ack, owner_id, load_data, 32'hA000_0000 + k);
            end
            req[0] = 1'b1;
        end
        set_data(0, 32'hB0B0_0099);
        step();
        vectors++;
        if ({load, ack, owner_id, load_data} !== {1'b1, 4'b0001, 2'd0, 32'hB0B0_0099}) begin
            miscompares++;
            $display("FAIL lock_forced_release: got load=%b ack=%b owner=%0d data=%h, expected owner 0 data b0b00099",
                     load, ack, owner_id, load_data);
        end
        req = '0; lock = '0;
        step();
        vectors++;
        if ({load, gnt, ack} !== '0) begin
            miscompares++;
            $display("FAIL lock_idle: got load=%b gnt=%b ack=%b, expected 0", load, gnt, ack);
        end
    endtask

    task automatic test_lock_drop();
        req = 4'b0100; lock = 4'b0100;
        for (int k = 1; k <= 3; k++) begin
            set_data(2, 32'hC000_0000 + k);
            step();
            vectors++;
            if ({load, ack, owner_id, load_data} !== {1'b1, 4'b0100, 2'd2, 32'hC000_0000 + k}) begin
                miscompares++;
                $display("FAIL lock_drop_burst[%0d]: got load=%b ack=%b owner=%0d data=%h, expected owner 2",
                         k, load, ack, owner_id, load_data);
            end
            req[3] = 1'b1;
            set_data(3, 32'hD000_0003);
        end
        req[2] = 1'b0;
        step();
        vectors++;
        if ({load, gnt, ack, load_data} !== {1'b0, 4'b0000, 4'b0000, 32'hC000_0003}) begin
            miscompares++;
            $display("FAIL lock_drop_gap: got load=%b gnt=%b ack=%b data=%h, expected 0 0000 0000 c0000003",
                     load, gnt, ack, load_data);
        end
        step();
        vectors++;
        if ({load, ack, owner_id, load_data} !== {1'b1, 4'b1000, 2'd3, 32'hD000_0003}) begin
            miscompares++;
            $display("FAIL lock_drop_next: got load=%b ack=%b owner=%0d data=%h, expected owner 3 data d0000003",
                     load, ack, owner_id, load_data);
        end
        req = '0; lock = '0;
        step();
    endtask

    task automatic test_reset_mid_burst();
        req = 4'b0010; lock = 4'b0010;
        set_data(1, 32'hE000_0001);
        step();
        set_data(1, 32'h1234_0FE6);
        rst = 1'b1;
        step();
        vectors++;
        if ({load, load_data, gnt, ack, owner_id} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_burst: got load=%b data=%h gnt=%b ack=%b owner=%0d, expected all zero",
                     load, load_data, gnt, ack, owner_id);
        end
        rst = 1'b0;
        req = 4'b1010; lock = '0;
        set_data(1, 32'h1111_0001); set_data(3, 32'h3333_0003);
        step();
        vectors++;
        if ({load, ack, owner_id, load_data} !== {1'b1, 4'b0010, 2'd1, 32'h1111_0001}) begin
            miscompares++;
            $display("FAIL reset_restart: got load=%b ack=%b owner=%0d data=%h, expected owner 1 data 11110001",
                     load, ack, owner_id, load_data);
        end
        req = '0;
        step();
    endtask

    task automatic test_random();
        rst = 1'b1; req = '0; lock = '0;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (m_ack[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if (!req[i]) req[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                lock[i] = ($urandom_range(0, 2) != 0);
                set_data(i, $urandom());
            end
            step();
            vectors++;
            if ({load, load_data, gnt, ack, owner_id} !== {m_load, m_data, m_gnt, m_ack, m_owner}) begin
                miscompares++;
                $display("FAIL random[%0d]: got load=%b data=%h gnt=%b ack=%b owner=%0d, expected load=%b data=%h gnt=%b ack=%b owner=%0d",
                         c, load, load_data, gnt, ack, owner_id, m_load, m_data, m_gnt, m_ack, m_owner);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; lock = '0; wdata = '0;
        test_reset();
        test_round_robin();
        test_single();
        test_priority();
        test_lock_max();
        test_lock_drop();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
